// File: rtl/id_ex_pkg.sv
// Shared decode constants for the ID/EX stage: opcodes, ALU function codes,
// immediate formats and the registered control bundle.
package id_ex_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SR   = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   typedef enum logic [1:0] {OP1_RS1, OP1_ZERO, OP1_PC} op1_sel_e;
   typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

   // All-zero encoding is the bubble: invalid, no write, no side effects.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] alu_op;
      logic       f7b5;
      logic       is_r;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
      logic       is_jal;
      logic       is_jalr;
      op1_sel_e   op1_sel;
      op2_sel_e   op2_sel;
   } id_ex_ctl_t;

   function automatic imm_type_e imm_type_of(input logic [6:0] opc);
      case (opc)
         OPC_STORE:          return IMM_S;
         OPC_BRANCH:         return IMM_B;
         OPC_LUI, OPC_AUIPC: return IMM_U;
         OPC_JAL:            return IMM_J;
         default:            return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Instruction word to sign-extended immediate, purely combinational.
// Format is picked from the opcode; XLEN must be at least 32.
module id_ex_stage_imm_gen
   import id_ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm
);
   logic [31:0] w_imm32;

   always_comb begin
      w_imm32 = '0;
      case (imm_type_of(i_instr[6:0]))
         IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                             i_instr[11:8], 1'b0};
         IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
         IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                             i_instr[30:21], 1'b0};
         default: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      endcase
   end

   assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: decodes IF/ID, registers into ID/EX, forwards EX/MEM
// and MEM/WB results, and raises a one-cycle stall on load-use (flush wins).
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int FWD_EN = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_idValid,
   input  logic [31:0]     i_idInstr,
   input  logic [XLEN-1:0] i_idPC,
   input  logic [XLEN-1:0] i_rs1Data,
   input  logic [XLEN-1:0] i_rs2Data,
   input  logic            i_flush,
   input  logic [4:0]      i_exmRd,
   input  logic            i_exmWe,
   input  logic [XLEN-1:0] i_exmResult,
   input  logic [4:0]      i_wbRd,
   input  logic            i_wbWe,
   input  logic [XLEN-1:0] i_wbResult,
   output logic            o_stall,
   output logic            o_exValid,
   output logic [XLEN-1:0] o_aluIn1,
   output logic [XLEN-1:0] o_aluIn2,
   output logic [2:0]      o_aluOP,
   output logic            o_funct7b5,
   output logic            o_isR,
   output logic [4:0]      o_exRd,
   output logic            o_exWe,
   output logic            o_exIsLoad,
   output logic            o_exIsStore,
   output logic            o_exIsBranch,
   output logic            o_exIsJal,
   output logic            o_exIsJalr,
   output logic [XLEN-1:0] o_exPC,
   output logic [XLEN-1:0] o_exImm,
   output logic [XLEN-1:0] o_exStoreData
);
   id_ex_ctl_t      r_ctl, w_ctl;
   logic [XLEN-1:0] r_pc, r_imm, r_rs1_val, r_rs2_val;
   logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val, w_fwd1, w_fwd2;
   logic [6:0]      w_opc;
   logic [4:0]      w_rs1, w_rs2, w_rd;
   logic            w_use1, w_use2, w_writes, w_load_use, w_raw_any;

   assign w_opc = i_idInstr[6:0];
   assign w_rd  = i_idInstr[11:7];
   assign w_rs1 = i_idInstr[19:15];
   assign w_rs2 = i_idInstr[24:20];

   assign w_use1 = !(w_opc == OPC_LUI || w_opc == OPC_AUIPC || w_opc == OPC_JAL);
   assign w_use2 = (w_opc == OPC_OP || w_opc == OPC_BRANCH || w_opc == OPC_STORE);

   id_ex_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .i_instr (i_idInstr),
      .o_imm   (w_imm)
   );

   always_comb begin
      w_ctl         = '0;
      w_writes      = 1'b0;
      w_ctl.valid   = 1'b1;
      w_ctl.rd      = w_rd;
      w_ctl.rs1     = w_use1 ? w_rs1 : 5'd0;
      w_ctl.rs2     = w_use2 ? w_rs2 : 5'd0;
      w_ctl.f7b5    = i_idInstr[30];
      w_ctl.alu_op  = ALU_ADD;
      w_ctl.op1_sel = OP1_RS1;
      w_ctl.op2_sel = OP2_IMM;
      case (w_opc)
         OPC_OP:     begin w_ctl.is_r = 1'b1; w_ctl.alu_op = i_idInstr[14:12];
                           w_ctl.op2_sel = OP2_RS2; w_writes = 1'b1; end
         OPC_OPIMM:  begin w_ctl.alu_op = i_idInstr[14:12]; w_writes = 1'b1; end
         OPC_LOAD:   begin w_ctl.is_load = 1'b1; w_writes = 1'b1; end
         OPC_STORE:  w_ctl.is_store = 1'b1;
         OPC_BRANCH: begin w_ctl.is_branch = 1'b1; w_ctl.alu_op = i_idInstr[14:12];
                           w_ctl.op2_sel = OP2_RS2; end
         OPC_LUI:    begin w_ctl.op1_sel = OP1_ZERO; w_writes = 1'b1; end
         OPC_AUIPC:  begin w_ctl.op1_sel = OP1_PC; w_writes = 1'b1; end
         OPC_JAL:    begin w_ctl.is_jal = 1'b1; w_ctl.op1_sel = OP1_PC;
                           w_ctl.op2_sel = OP2_FOUR; w_writes = 1'b1; end
         OPC_JALR:   begin w_ctl.is_jalr = 1'b1; w_ctl.op1_sel = OP1_PC;
                           w_ctl.op2_sel = OP2_FOUR; w_writes = 1'b1; end
         default:    ;
      endcase
      w_ctl.we = w_writes && (w_rd != 5'd0);
   end

   // Same-cycle write-back is not yet visible in the regfile read data.
   assign w_rs1_val = (i_wbWe && i_wbRd != 5'd0 && i_wbRd == w_ctl.rs1) ? i_wbResult : i_rs1Data;
   assign w_rs2_val = (i_wbWe && i_wbRd != 5'd0 && i_wbRd == w_ctl.rs2) ? i_wbResult : i_rs2Data;

   assign w_load_use = r_ctl.valid && r_ctl.is_load && r_ctl.rd != 5'd0 && i_idValid &&
                       ((w_use1 && w_rs1 == r_ctl.rd) || (w_use2 && w_rs2 == r_ctl.rd));

   assign w_raw_any = i_idValid && (
         (r_ctl.we && ((w_use1 && w_rs1 == r_ctl.rd) || (w_use2 && w_rs2 == r_ctl.rd))) ||
         (i_exmWe && i_exmRd != 5'd0 &&
          ((w_use1 && w_rs1 == i_exmRd) || (w_use2 && w_rs2 == i_exmRd))) ||
         (i_wbWe && i_wbRd != 5'd0 &&
          ((w_use1 && w_rs1 == i_wbRd) || (w_use2 && w_rs2 == i_wbRd))));

   assign o_stall = !i_flush && ((FWD_EN != 0) ? w_load_use : w_raw_any);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush || o_stall || !i_idValid) begin
         r_ctl     <= '0;
         r_pc      <= '0;
         r_imm     <= '0;
         r_rs1_val <= '0;
         r_rs2_val <= '0;
      end else begin
         r_ctl     <= w_ctl;
         r_pc      <= i_idPC;
         r_imm     <= w_imm;
         r_rs1_val <= w_rs1_val;
         r_rs2_val <= w_rs2_val;
      end
   end

   always_comb begin
      w_fwd1 = r_rs1_val;
      if (FWD_EN != 0 && i_exmWe && i_exmRd != 5'd0 && i_exmRd == r_ctl.rs1)
         w_fwd1 = i_exmResult;
      else if (FWD_EN != 0 && i_wbWe && i_wbRd != 5'd0 && i_wbRd == r_ctl.rs1)
         w_fwd1 = i_wbResult;
      w_fwd2 = r_rs2_val;
      if (FWD_EN != 0 && i_exmWe && i_exmRd != 5'd0 && i_exmRd == r_ctl.rs2)
         w_fwd2 = i_exmResult;
      else if (FWD_EN != 0 && i_wbWe && i_wbRd != 5'd0 && i_wbRd == r_ctl.rs2)
         w_fwd2 = i_wbResult;
   end

   always_comb begin
      case (r_ctl.op1_sel)
         OP1_ZERO: o_aluIn1 = '0;
         OP1_PC:   o_aluIn1 = r_pc;
         default:  o_aluIn1 = w_fwd1;
      endcase
      case (r_ctl.op2_sel)
         OP2_RS2:  o_aluIn2 = w_fwd2;
         OP2_FOUR: o_aluIn2 = XLEN'(4);
         default:  o_aluIn2 = r_imm;
      endcase
   end

   assign o_exValid     = r_ctl.valid;
   assign o_aluOP       = r_ctl.alu_op;
   assign o_funct7b5    = r_ctl.f7b5;
   assign o_isR         = r_ctl.is_r;
   assign o_exRd        = r_ctl.rd;
   assign o_exWe        = r_ctl.we;
   assign o_exIsLoad    = r_ctl.is_load;
   assign o_exIsStore   = r_ctl.is_store;
   assign o_exIsBranch  = r_ctl.is_branch;
   assign o_exIsJal     = r_ctl.is_jal;
   assign o_exIsJalr    = r_ctl.is_jalr;
   assign o_exPC        = r_pc;
   assign o_exImm       = r_imm;
   assign o_exStoreData = w_fwd2;

endmodule
